mdr_mem_ctrl: RTL and testbench

Parametrised memory data register with a registered memory handshake, sub-word access and wait-state timeout. It sits between the internal bus and the memory port, replacing the plain MDR. Read data is captured only on memory acknowledge, with byte/halfword lane extraction and sign/zero extension. Writes drive MDR contents onto the correct byte lanes with byte enables.

---
 rtl/mdr_pkg.sv | 29 ++
 rtl/mdr_lane_align.sv | 50 +++++
 rtl/mdr_mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mdr_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// mdr_pkg: shared types and helpers for the memory data register controller.
//   size_t      - access size encoding (11 is treated as a word access)
//   mdr_state_t - controller states
//   lane_index  - byte-lane index for an access of a given size and low address
package mdr_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10
    } mdr_state_t;

    // Halfwords are aligned down to an even lane; words always start at lane 0.
    function automatic int unsigned lane_index(logic [1:0] size, int unsigned addr);
        if (size == SZ_BYTE) begin
            return addr;
        end else if (size == SZ_HALF) begin
            return addr & ~32'd1;
        end
        return 0;
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// mdr_lane_align: combinational byte-lane steering for the MDR.
//   size     in  access size (size_t encoding)
//   lane     in  starting byte lane
//   sign_ext in  sign-extend sub-word read data
//   rdata    in  raw memory read data
//   q        in  current MDR contents
//   rd_ext   out read value extracted from the lane and extended to DATA_W
//   wr_data  out low sub-word of q placed on the lane, other lanes zero
//   be       out byte enables for the selected lanes
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned LANE_W = $clog2(DATA_W / 8),
    localparam int unsigned NB = DATA_W / 8
) (
    input  logic [1:0]        size,
    input  logic [LANE_W-1:0] lane,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] rd_ext,
    output logic [DATA_W-1:0] wr_data,
    output logic [NB-1:0]     be
);

    logic [LANE_W+2:0] sh;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    assign sh = {lane, 3'b000};

    always_comb begin
        rd_byte = rdata[sh +: 8];
        rd_half = rdata[sh +: 16];
        rd_ext  = rdata;
        wr_data = q;
        be      = '1;
        if (size == SZ_BYTE) begin
            rd_ext  = {{(DATA_W - 8){sign_ext & rd_byte[7]}}, rd_byte};
            wr_data = {{(DATA_W - 8){1'b0}}, q[7:0]} << sh;
            be      = NB'(1) << lane;
        end else if (size == SZ_HALF) begin
            rd_ext  = {{(DATA_W - 16){sign_ext & rd_half[15]}}, rd_half};
            wr_data = {{(DATA_W - 16){1'b0}}, q[15:0]} << sh;
            be      = NB'(3) << lane;
        end
    end

endmodule

// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl: memory data register with registered memory handshake,
// sub-word lane steering and a wait-state timeout.
//   clk, clr              clock, synchronous active-low reset
//   BusMuxOut, MDRin      internal bus data and MDR load strobe (IDLE only)
//   Read, Write           start a memory read / write of Q (IDLE only)
//   size, sign_ext, addr_lo  access shape, latched when an operation starts
//   Mdatain, mem_ack      memory read data and acknowledge
//   mem_rd_req, mem_wr_req   registered memory requests
//   Mdataout, mem_be      lane-placed write data and byte enables
//   Q                     MDR contents to the bus
//   busy, done, err       waiting, one-cycle completion pulse, sticky timeout
module mdr_mem_ctrl
    import mdr_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned LANE_W = $clog2(DATA_W / 8),
    localparam int unsigned NB = DATA_W / 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              mem_ack,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [DATA_W-1:0] Mdataout,
    output logic [NB-1:0]     mem_be,
    output logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Counter only needs to reach TIMEOUT-1: the edge ending the TIMEOUT-th
    // un-acked wait cycle is the one that fires the timeout.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    mdr_state_t        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [LANE_W-1:0] in_lane, al_lane;
    logic [1:0]        al_size;
    logic              al_sext;
    logic [DATA_W-1:0] al_rd, al_wr;
    logic [NB-1:0]     al_be;
    logic              timeout_hit;

    // In IDLE the aligner sees the live inputs so write data/enables can be
    // registered on the accepting edge; in the wait states it sees the latched shape.
    assign in_lane = LANE_W'(lane_index(size, 32'(addr_lo)));
    assign al_size = (state_q == IDLE) ? size : size_q;
    assign al_lane = (state_q == IDLE) ? in_lane : lane_q;
    assign al_sext = (state_q == IDLE) ? sign_ext : sext_q;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    mdr_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size     (al_size),
        .lane     (al_lane),
        .sign_ext (al_sext),
        .rdata    (Mdatain),
        .q        (q_q),
        .rd_ext   (al_rd),
        .wr_data  (al_wr),
        .be       (al_be)
    );

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        sext_d  = sext_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    size_d  = size;
                    sext_d  = sign_ext;
                    lane_d  = in_lane;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (Read) begin
                        state_d = RD_WAIT;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = WR_WAIT;
                        wr_d    = 1'b1;
                        wdata_d = al_wr;
                        be_d    = al_be;
                    end
                end else if (MDRin) begin
                    q_d = BusMuxOut;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack || timeout_hit) begin
                    // Ack takes precedence over a simultaneous timeout.
                    state_d = IDLE;
                    wdata_d = '0;
                    be_d    = '0;
                    if (mem_ack) begin
                        done_d = 1'b1;
                        if (state_q == RD_WAIT) q_d = al_rd;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                    rd_d   = (state_q == RD_WAIT);
                    wr_d   = (state_q == WR_WAIT);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            size_q  <= '0;
            sext_q  <= 1'b0;
            lane_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd_req = rd_q;
    assign mem_wr_req = wr_q;
    assign Mdataout   = wdata_q;
    assign mem_be     = be_q;
    assign Q          = q_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Self-checking bench for mdr_mem_ctrl (DATA_W=32, TIMEOUT=4).
module tb_mdr_mem_ctrl;

    localparam int unsigned TO = 4;

    logic        clk, clr;
    logic [31:0] BusMuxOut, Mdatain, Mdataout, Q;
    logic        MDRin, Read, Write, sign_ext, mem_ack;
    logic [1:0]  size, addr_lo;
    logic        mem_rd_req, mem_wr_req, busy, done, err;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_fail = 0;

    mdr_mem_ctrl #(
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .BusMuxOut  (BusMuxOut),
        .MDRin      (MDRin),
        .Read       (Read),
        .Write      (Write),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr_lo    (addr_lo),
        .Mdatain    (Mdatain),
        .mem_ack    (mem_ack),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .Mdataout   (Mdataout),
        .mem_be     (mem_be),
        .Q          (Q),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_op;    // 0 none, 1 reading, 2 writing
    int          m_waits; // un-acked wait cycles so far
    int          m_bytes, m_lane;
    logic        m_se;
    logic [31:0] e_q, e_mdo;
    logic [3:0]  e_be;
    logic        e_rd, e_wr, e_busy, e_done, e_err;

    function automatic int nbytes_of(logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_of(logic [1:0] sz, int a);
        if (sz == 2'b00) return a;
        if (sz == 2'b01) return (a / 2) * 2;
        return 0;
    endfunction

    function automatic logic [31:0] read_value(logic [31:0] d, int nb, int lane, logic se);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(lane+i) +: 8];
        if (se && nb < 4 && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    initial begin
        m_op = 0; m_waits = 0; m_bytes = 4; m_lane = 0; m_se = 1'b0;
        e_q = '0; e_mdo = '0; e_be = '0;
        e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_err = 0;
        forever begin
            @(posedge clk);
            if (!clr) begin
                m_op = 0; m_waits = 0;
                e_q = '0; e_mdo = '0; e_be = '0;
                e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_err = 0;
            end else begin
                e_done = 0;
                if (m_op == 0) begin
                    if (Read || Write) begin
                        m_bytes = nbytes_of(size);
                        m_lane  = lane_of(size, int'(addr_lo));
                        m_se    = sign_ext;
                        m_waits = 0;
                        e_err   = 0;
                        e_busy  = 1;
                        if (Read) begin
                            m_op = 1; e_rd = 1;
                        end else begin
                            m_op  = 2; e_wr = 1;
                            e_mdo = '0; e_be = '0;
                            for (int i = 0; i < m_bytes; i++) begin
                                e_mdo[8*(m_lane+i) +: 8] = e_q[8*i +: 8];
                                e_be[m_lane+i] = 1'b1;
                            end
                        end
                    end else if (MDRin) begin
                        e_q = BusMuxOut;
                    end
                end else begin
                    m_waits = mem_ack ? m_waits : m_waits + 1;
                    if (mem_ack) begin
                        if (m_op == 1) e_q = read_value(Mdatain, m_bytes, m_lane, m_se);
                        e_done = 1;
                    end else if (m_waits == TO) begin
                        e_err = 1;
                    end
                    if (mem_ack || m_waits == TO) begin
                        m_op = 0; e_rd = 0; e_wr = 0; e_busy = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_Q", Q, e_q);
            chk("cyc_rd_req", 32'(mem_rd_req), 32'(e_rd));
            chk("cyc_wr_req", 32'(mem_wr_req), 32'(e_wr));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_done", 32'(done), 32'(e_done));
            chk("cyc_err", 32'(err), 32'(e_err));
            if (e_wr) begin
                chk("cyc_Mdataout", Mdataout, e_mdo);
                chk("cyc_mem_be", 32'(mem_be), 32'(e_be));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_Q"}, Q, 32'h0);
        chk({tag, "_mdo"}, Mdataout, 32'h0);
        chk({tag, "_be"}, 32'(mem_be), 32'h0);
        chk({tag, "_req"}, {30'h0, mem_rd_req, mem_wr_req}, 32'h0);
        chk({tag, "_flags"}, {29'h0, busy, done, err}, 32'h0);
    endtask

    initial begin
        clr = 0; BusMuxOut = '0; Mdatain = '0; MDRin = 0; Read = 0; Write = 0;
        size = 2'b10; sign_ext = 0; addr_lo = 0; mem_ack = 0;
        tick(); tick();
        chk_all_zero("reset");
        clr = 1;

        BusMuxOut = 32'h12345678; MDRin = 1; tick(); MDRin = 0;
        chk("mdrin_load", Q, 32'h12345678);

        // word read, ack on first wait cycle
        Read = 1; size = 2'b10; Mdatain = 32'hDEADBEEF; tick(); Read = 0;
        chk("wrd_req", 32'(mem_rd_req), 32'd1);
        chk("wrd_no_done_yet", 32'(done), 32'd0);
        mem_ack = 1; tick(); mem_ack = 0;
        chk("wrd_Q", Q, 32'hDEADBEEF);
        chk("wrd_done", 32'(done), 32'd1);
        chk("wrd_req_drop", 32'(mem_rd_req), 32'd0);
        tick();
        chk("wrd_done_one_cycle", 32'(done), 32'd0);

        // byte read, sign-extended; live inputs change after accept
        Read = 1; size = 2'b00; addr_lo = 2; sign_ext = 1; Mdatain = 32'h0080FF00;
        tick(); Read = 0;
        size = 2'b10; addr_lo = 0; sign_ext = 0;
        mem_ack = 1; tick(); mem_ack = 0;
        chk("byte_sext", Q, 32'hFFFFFF80);

        // byte read, zero-extended, ack in second wait cycle
        Read = 1; size = 2'b00; addr_lo = 2; sign_ext = 0; tick(); Read = 0;
        tick();
        chk("byte_zext_busy", 32'(busy), 32'd1);
        mem_ack = 1; tick(); mem_ack = 0;
        chk("byte_zext", Q, 32'h00000080);

        // misaligned half read aligns down to lane 0
        Read = 1; size = 2'b01; addr_lo = 1; sign_ext = 1; Mdatain = 32'h12348765;
        tick(); Read = 0; mem_ack = 1; tick(); mem_ack = 0;
        chk("half_misalign", Q, 32'hFFFF8765);

        // half write at addr 3 -> lanes 2,3
        BusMuxOut = 32'h0000A55A; MDRin = 1; tick(); MDRin = 0;
        Write = 1; size = 2'b01; addr_lo = 3; tick(); Write = 0;
        chk("hw_req", 32'(mem_wr_req), 32'd1);
        chk("hw_mdo", Mdataout, 32'hA55A0000);
        chk("hw_be", 32'(mem_be), 32'h0000000C);
        tick();
        chk("hw_mdo_hold", Mdataout, 32'hA55A0000);
        mem_ack = 1; tick(); mem_ack = 0;
        chk("hw_done", 32'(done), 32'd1);
        chk("hw_Q_kept", Q, 32'h0000A55A);

        // read timeout after TO un-acked wait cycles
        Read = 1; size = 2'b10; Mdatain = 32'hFFFFFFFF; tick(); Read = 0;
        tick(); tick(); tick();
        chk("to_err_early", 32'(err), 32'd0);
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_req_drop", 32'(mem_rd_req), 32'd0);
        chk("to_no_done", 32'(done), 32'd0);
        chk("to_Q_kept", Q, 32'h0000A55A);
        tick();
        chk("to_err_sticky", 32'(err), 32'd1);

        // next read clears err; new write accepted in the done cycle
        Read = 1; Mdatain = 32'h0BADF00D; tick(); Read = 0;
        chk("err_cleared", 32'(err), 32'd0);
        mem_ack = 1; tick(); mem_ack = 0;
        Write = 1; size = 2'b10; tick(); Write = 0;
        chk("b2b_wr_req", 32'(mem_wr_req), 32'd1);
        chk("b2b_mdo", Mdataout, 32'h0BADF00D);
        chk("b2b_be", 32'(mem_be), 32'h0000000F);
        mem_ack = 1; tick(); mem_ack = 0;

        // Read > Write > MDRin; MDRin ignored while waiting
        BusMuxOut = 32'hCAFEF00D; Read = 1; Write = 1; MDRin = 1; Mdatain = 32'h11112222;
        tick(); Read = 0; Write = 0; MDRin = 0;
        chk("prio_rd", 32'(mem_rd_req), 32'd1);
        chk("prio_no_wr", 32'(mem_wr_req), 32'd0);
        chk("prio_no_load", Q, 32'h0BADF00D);
        BusMuxOut = 32'h5555AAAA; MDRin = 1; tick(); MDRin = 0;
        chk("mdrin_ignored", Q, 32'h0BADF00D);
        mem_ack = 1; tick(); mem_ack = 0;
        chk("prio_Q", Q, 32'h11112222);

        // ack while idle does nothing
        tick();
        Mdatain = 32'h99999999; mem_ack = 1; tick(); mem_ack = 0;
        chk("idle_ack_Q", Q, 32'h11112222);
        chk("idle_ack_done", 32'(done), 32'd0);

        // write timeout, byte at lane 1 (model-checked)
        Write = 1; size = 2'b00; addr_lo = 1; tick(); Write = 0;
        chk("bw_mdo", Mdataout, 32'h00002200);
        repeat (TO + 1) tick();

        // reset mid-read
        Read = 1; size = 2'b10; tick(); Read = 0;
        clr = 0; tick(); clr = 1;
        chk_all_zero("rst_rd");

        // reset mid-write
        BusMuxOut = 32'h76543210; MDRin = 1; tick(); MDRin = 0;
        Write = 1; tick(); Write = 0;
        clr = 0; tick(); clr = 1;
        chk_all_zero("rst_wr");
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
